// File: rtl/ibex_cx_ctrl.sv
// ibex_cx_ctrl: sequences CX_REG/CX_IMM/CX_FLEX instructions to composable extension units with timeout, kill and drain handling.
module ibex_cx_ctrl #(
  parameter int NUM_CXU = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cx_valid_i,
  input  logic [1:0]         cx_kind_i,
  input  logic [9:0]         cx_funct_i,
  input  logic [31:0]        cx_op_a_i,
  input  logic [31:0]        cx_op_b_i,
  input  logic [7:0]         cx_idx_i,
  input  logic               mcx_en_i,
  input  logic               kill_i,
  output logic               cx_stall_o,
  output logic               cx_we_o,
  output logic [31:0]        cx_result_o,
  output logic               cx_illegal_o,
  output logic               cx_stat_we_o,
  output logic [31:0]        cx_stat_o,
  output logic               cxu_req_valid_o,
  output logic [NUM_CXU-1:0] cxu_sel_o,
  output logic [1:0]         cxu_req_kind_o,
  output logic [9:0]         cxu_req_funct_o,
  output logic [31:0]        cxu_req_a_o,
  output logic [31:0]        cxu_req_b_o,
  input  logic               cxu_req_ready_i,
  input  logic               cxu_resp_valid_i,
  input  logic [31:0]        cxu_resp_data_i,
  input  logic               cxu_resp_err_i
);
  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, DRAIN} state_t;
  state_t state, state_nxt;
  logic [1:0] kind;
  logic [9:0] funct;
  logic [31:0] op_a, op_b, data;
  logic [7:0] idx, cnt;
  logic err, tout, drn;
  logic bad, accept, hit;
  assign bad = !mcx_en_i || int'(cx_idx_i) >= NUM_CXU || cx_kind_i == 2'b11;
  assign accept = state == IDLE && cx_valid_i && !kill_i && !bad;
  // hit marks the TIMEOUT-th cycle spent in REQ+RESP
  assign hit = cnt + 8'd1 == 8'(TIMEOUT);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = accept ? REQ : IDLE;
      REQ: begin
        if (kill_i) state_nxt = cxu_req_ready_i ? DRAIN : IDLE;
        else if (hit) state_nxt = DONE;
        else if (cxu_req_ready_i) state_nxt = RESP;
      end
      RESP: begin
        if (kill_i) state_nxt = cxu_resp_valid_i ? IDLE : DRAIN;
        else if (cxu_resp_valid_i || hit) state_nxt = DONE;
      end
      DONE: state_nxt = drn ? DRAIN : IDLE;
      DRAIN: state_nxt = cxu_resp_valid_i ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      kind <= '0;
      funct <= '0;
      op_a <= '0;
      op_b <= '0;
      idx <= '0;
      cnt <= '0;
      data <= '0;
      err <= 1'b0;
      tout <= 1'b0;
      drn <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        kind <= cx_kind_i;
        funct <= cx_funct_i;
        op_a <= cx_op_a_i;
        op_b <= cx_op_b_i;
        idx <= cx_idx_i;
        cnt <= '0;
        data <= '0;
        err <= 1'b0;
        tout <= 1'b0;
        drn <= 1'b0;
      end
      if (state == REQ || state == RESP) cnt <= cnt + 8'd1;
      // a request accepted on the timeout cycle leaves a response in flight
      if (state == REQ && !kill_i && hit) begin
        tout <= 1'b1;
        drn <= cxu_req_ready_i;
      end
      if (state == RESP && !kill_i) begin
        if (cxu_resp_valid_i) begin
          data <= cxu_resp_data_i;
          err <= cxu_resp_err_i;
        end else if (hit) begin
          tout <= 1'b1;
          drn <= 1'b1;
        end
      end
    end
  end
  assign cx_illegal_o = state == IDLE && cx_valid_i && !kill_i && bad;
  assign cx_stall_o = accept || state == REQ || state == RESP;
  assign cxu_req_valid_o = state == REQ;
  assign cxu_sel_o = state == REQ ? NUM_CXU'(1) << idx : '0;
  assign cxu_req_kind_o = kind;
  assign cxu_req_funct_o = funct;
  assign cxu_req_a_o = op_a;
  assign cxu_req_b_o = op_b;
  assign cx_we_o = state == DONE && !kill_i;
  assign cx_stat_we_o = state == DONE;
  assign cx_result_o = state == DONE && !err && !tout ? data : '0;
  assign cx_stat_o = state == DONE ? {16'b0, idx, 6'b0, tout, err} : '0;
endmodule
